// File: rtl/ddr_init_sequencer.sv
// Multi-channel DDR hard-IP reset/start sequencer with per-channel done tracking.
// Optional DDR_INIT_TIMEOUT_EN builds the START timeout, bounded retry and ERR state.
module ddr_init_sequencer #(
    parameter int pChannels      = 1,
    parameter int pRstCycles     = 16,
    parameter int pWaitCycles    = 255,
    parameter int pTimeoutCycles = 65536,
    parameter int pMaxRetry      = 3
) (
    input  logic                 iCLK,
    input  logic                 iRST,
    input  logic                 i_restart,
    input  logic [pChannels-1:0] i_ddr_cfg_done,
    output logic [pChannels-1:0] o_ddr_axi_rstn,
    output logic [pChannels-1:0] o_ddr_cfg_reset,
    output logic [pChannels-1:0] o_ddr_cfg_start,
    output logic                 o_ddr_cfg_done,
    output logic                 o_ddr_init_err,
    output logic [3:0]           o_retry_cnt
);

    localparam int cRstWait = (pRstCycles > pWaitCycles) ? pRstCycles : pWaitCycles;
`ifdef DDR_INIT_TIMEOUT_EN
    localparam int cCntMax  = (cRstWait > pTimeoutCycles) ? cRstWait : pTimeoutCycles;
`else
    localparam int cCntMax  = cRstWait;
`endif
    localparam int cCntW    = $clog2(cCntMax) + 1;

    if (pChannels < 1 || pChannels > 4 || pRstCycles < 1 || pWaitCycles < 1 ||
        pTimeoutCycles < 4 || pMaxRetry < 0 || pMaxRetry > 15) begin : g_bad_cfg
        $error("ddr_init_sequencer: parameter out of range");
    end

    typedef enum logic [2:0] {ST_RST, ST_WAIT, ST_START, ST_DONE, ST_ERR} state_t;

    state_t                 state, state_nxt;
    logic [cCntW-1:0]       cnt;
    logic                   cnt_clr;
    logic [pChannels-1:0]   mask, mask_nxt, done_all;
    logic [pChannels-1:0]   done_sync1, done_sync2;
    logic [3:0]             retry;
`ifdef DDR_INIT_TIMEOUT_EN
    logic [3:0]             retry_nxt;
`endif

    always_comb begin
        state_nxt = state;
        cnt_clr   = 1'b0;
        mask_nxt  = mask;
        done_all  = mask | done_sync2;
`ifdef DDR_INIT_TIMEOUT_EN
        retry_nxt = retry;
`endif
        if (i_restart) begin
            state_nxt = ST_RST;
            cnt_clr   = 1'b1;
            mask_nxt  = '0;
`ifdef DDR_INIT_TIMEOUT_EN
            retry_nxt = '0;
`endif
        end else begin
            case (state)
                ST_RST: begin
                    if (cnt == cCntW'(pRstCycles - 1)) begin
                        state_nxt = ST_WAIT;
                        cnt_clr   = 1'b1;
                    end
                end
                ST_WAIT: begin
                    if (cnt == cCntW'(pWaitCycles - 1)) begin
                        state_nxt = ST_START;
                        cnt_clr   = 1'b1;
                        mask_nxt  = '0;
                    end
                end
                ST_START: begin
                    mask_nxt = done_all;
                    // A full mask on the final timeout count still completes.
                    if (&done_all) begin
                        state_nxt = ST_DONE;
                        cnt_clr   = 1'b1;
                    end
`ifdef DDR_INIT_TIMEOUT_EN
                    else if (cnt == cCntW'(pTimeoutCycles - 1)) begin
                        cnt_clr  = 1'b1;
                        mask_nxt = '0;
                        if (retry < 4'(pMaxRetry)) begin
                            retry_nxt = retry + 4'd1;
                            state_nxt = ST_RST;
                        end else begin
                            state_nxt = ST_ERR;
                        end
                    end
`endif
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge iCLK or posedge iRST) begin
        if (iRST) begin
            state           <= ST_RST;
            cnt             <= '0;
            mask            <= '0;
            done_sync1      <= '0;
            done_sync2      <= '0;
            o_ddr_cfg_reset <= '1;
            o_ddr_axi_rstn  <= '0;
            o_ddr_cfg_start <= '0;
            o_ddr_cfg_done  <= 1'b0;
        end else begin
            state           <= state_nxt;
            cnt             <= cnt_clr ? '0 : cnt + cCntW'(1);
            mask            <= mask_nxt;
            done_sync1      <= i_ddr_cfg_done;
            done_sync2      <= done_sync1;
            // Outputs are decoded from the next state so they change with it.
            o_ddr_cfg_reset <= {pChannels{(state_nxt == ST_RST) || (state_nxt == ST_ERR)}};
            o_ddr_axi_rstn  <= {pChannels{state_nxt == ST_DONE}};
            o_ddr_cfg_start <= {pChannels{(state_nxt == ST_START) || (state_nxt == ST_DONE)}};
            o_ddr_cfg_done  <= (state_nxt == ST_DONE);
        end
    end

`ifdef DDR_INIT_TIMEOUT_EN
    always_ff @(posedge iCLK or posedge iRST) begin
        if (iRST) begin
            retry          <= '0;
            o_ddr_init_err <= 1'b0;
        end else begin
            retry          <= retry_nxt;
            o_ddr_init_err <= (state_nxt == ST_ERR);
        end
    end
`else
    assign retry          = '0;
    assign o_ddr_init_err = 1'b0;
`endif

    assign o_retry_cnt = retry;

endmodule

// File: tb/tb_ddr_init_sequencer.sv
// Bench for ddr_init_sequencer: outputs compared every cycle against a timeline
// derived arithmetically from reset/wait/timeout windows and done arrival times.
module tb_ddr_init_sequencer;

    localparam int R = 4;
    localparam int W = 8;
    localparam int T = 64;
    localparam int M = 2;
    localparam int P = R + W + T;
    localparam int NEVER = 100000;
    localparam logic [11:0] RESET_VEC = {2'b00, 2'b11, 2'b00, 1'b0, 1'b0, 4'd0};

    logic       iCLK = 1'b0;
    logic       iRST;
    logic       i_restart;
    logic [1:0] done_in;
    logic [1:0] o_ddr_axi_rstn, o_ddr_cfg_reset, o_ddr_cfg_start;
    logic       o_ddr_cfg_done, o_ddr_init_err;
    logic [3:0] o_retry_cnt;

    int e, total, passed;
    logic [11:0] got, exp;

    always #5 iCLK = ~iCLK;

    ddr_init_sequencer #(
        .pChannels(2), .pRstCycles(R), .pWaitCycles(W), .pTimeoutCycles(T), .pMaxRetry(M)
    ) dut (
        .iCLK(iCLK), .iRST(iRST), .i_restart(i_restart), .i_ddr_cfg_done(done_in),
        .o_ddr_axi_rstn(o_ddr_axi_rstn), .o_ddr_cfg_reset(o_ddr_cfg_reset),
        .o_ddr_cfg_start(o_ddr_cfg_start), .o_ddr_cfg_done(o_ddr_cfg_done),
        .o_ddr_init_err(o_ddr_init_err), .o_retry_cnt(o_retry_cnt)
    );

    // Expected outputs e edges after (re)start, given the edge d at which completion lands (-1: never).
    function automatic logic [11:0] model(input int ev, input int d);
        int k, ph;
        logic [1:0] cr, st;
`ifdef DDR_INIT_TIMEOUT_EN
        if (d >= 0 && ev >= d) return {2'b11, 2'b00, 2'b11, 1'b1, 1'b0, 4'((d - 1) / P)};
        if (ev >= P * (M + 1)) return {2'b00, 2'b11, 2'b00, 1'b0, 1'b1, 4'(M)};
        k  = ev / P;
        ph = ev % P;
`else
        if (d >= 0 && ev >= d) return {2'b11, 2'b00, 2'b11, 1'b1, 1'b0, 4'd0};
        k  = 0;
        ph = ev;
`endif
        cr = (ph < R) ? 2'b11 : 2'b00;
        st = (ph >= R + W) ? 2'b11 : 2'b00;
        return {2'b00, cr, st, 1'b0, 1'b0, 4'(k)};
    endfunction

    function automatic logic [11:0] observe();
        return {o_ddr_axi_rstn, o_ddr_cfg_reset, o_ddr_cfg_start, o_ddr_cfg_done, o_ddr_init_err, o_retry_cnt};
    endfunction

    task automatic tick();
        @(posedge iCLK);
        e++;
        @(negedge iCLK);
    endtask

    task automatic drive(input int c0, input int l0, input int c1, input int l1);
        done_in[0] = (e >= c0) && (l0 == 0 || e < c0 + l0);
        done_in[1] = (e >= c1) && (l1 == 0 || e < c1 + l1);
    endtask

    task automatic apply_reset();
        iRST = 1'b1;
        i_restart = 1'b0;
        done_in = '0;
        repeat (2) @(negedge iCLK);
        iRST = 1'b0;
        e = 0;
    endtask

    task automatic test_reset();
        iRST = 1'b1;
        i_restart = 1'b0;
        done_in = '1;
        #1;
        got = observe(); total++;
        if (got !== RESET_VEC) $display("FAIL reset_async got=%h exp=%h", got, RESET_VEC); else passed++;
        repeat (3) begin
            @(negedge iCLK);
            got = observe(); total++;
            if (got !== RESET_VEC) $display("FAIL reset_hold got=%h exp=%h", got, RESET_VEC); else passed++;
        end
        iRST = 1'b0;
        done_in = '0;
        e = 0;
        while (e < 16) begin
            got = observe(); exp = model(e, -1); total++;
            if (got !== exp) $display("FAIL release_timing e=%0d got=%h exp=%h", e, got, exp); else passed++;
            tick();
        end
    endtask

    task automatic test_basic();
        apply_reset();
        while (e <= 40) begin
            drive(20, 0, 30, 0);
            got = observe(); exp = model(e, 33); total++;
            if (got !== exp) $display("FAIL basic e=%0d got=%h exp=%h", e, got, exp); else passed++;
            tick();
        end
    endtask

    task automatic test_sticky();
        apply_reset();
        while (e <= 50) begin
            drive(20, 1, 40, 0);
            got = observe(); exp = model(e, 43); total++;
            if (got !== exp) $display("FAIL sticky e=%0d got=%h exp=%h", e, got, exp); else passed++;
            tick();
        end
    endtask

    task automatic test_random();
        for (int it = 0; it < 6; it++) begin
            int c0, c1, l0, l1, d;
            c0 = int'($urandom_range(12, 70));
            c1 = int'($urandom_range(12, 70));
            l0 = int'($urandom_range(0, 3));
            l1 = int'($urandom_range(0, 3));
            d  = ((c0 > c1) ? c0 : c1) + 3;
            apply_reset();
            while (e <= d + 6) begin
                if (e >= d + 2) done_in = '0;
                else drive(c0, l0, c1, l1);
                got = observe(); exp = model(e, d); total++;
                if (got !== exp) $display("FAIL random it=%0d e=%0d got=%h exp=%h", it, e, got, exp); else passed++;
                tick();
            end
        end
    endtask

    task automatic test_restart_in_rst();
        apply_reset();
        tick();
        tick();
        i_restart = 1'b1;
        tick();
        i_restart = 1'b0;
        e = 0;
        while (e <= 22) begin
            drive(14, 0, 14, 0);
            got = observe(); exp = model(e, 17); total++;
            if (got !== exp) $display("FAIL restart_in_rst e=%0d got=%h exp=%h", e, got, exp); else passed++;
            tick();
        end
    endtask

    task automatic test_restart_vs_completion();
        apply_reset();
        while (e < 22) begin
            drive(20, 0, 20, 0);
            tick();
        end
        i_restart = 1'b1;
        tick();
        i_restart = 1'b0;
        e = 0;
        while (e <= 18) begin
            got = observe(); exp = model(e, 13); total++;
            if (got !== exp) $display("FAIL restart_vs_done e=%0d got=%h exp=%h", e, got, exp); else passed++;
            tick();
        end
    endtask

    task automatic test_async_reset();
        apply_reset();
        while (e < 15) tick();
        #2 iRST = 1'b1;
        #1;
        got = observe(); total++;
        if (got !== RESET_VEC) $display("FAIL midrun_reset got=%h exp=%h", got, RESET_VEC); else passed++;
        @(negedge iCLK);
        iRST = 1'b0;
        e = 0;
        while (e <= 35) begin
            drive(25, 0, 27, 0);
            got = observe(); exp = model(e, 30); total++;
            if (got !== exp) $display("FAIL after_midrun_reset e=%0d got=%h exp=%h", e, got, exp); else passed++;
            tick();
        end
    endtask

`ifdef DDR_INIT_TIMEOUT_EN
    task automatic test_timeout();
        apply_reset();
        while (e <= P * (M + 1) + 8) begin
            got = observe(); exp = model(e, -1); total++;
            if (got !== exp) $display("FAIL timeout e=%0d got=%h exp=%h", e, got, exp); else passed++;
            tick();
        end
    endtask

    task automatic test_restart_err();
        done_in = '1;
        i_restart = 1'b1;
        tick();
        i_restart = 1'b0;
        e = 0;
        while (e <= 18) begin
            got = observe(); exp = model(e, 13); total++;
            if (got !== exp) $display("FAIL restart_err e=%0d got=%h exp=%h", e, got, exp); else passed++;
            tick();
        end
    endtask

    task automatic test_timeout_boundary();
        for (int c = 73; c <= 74; c++) begin
            int d;
            d = (c == 73) ? 76 : 89;
            apply_reset();
            while (e <= d + 4) begin
                drive(c, 0, c, 0);
                got = observe(); exp = model(e, d); total++;
                if (got !== exp) $display("FAIL timeout_edge c=%0d e=%0d got=%h exp=%h", c, e, got, exp); else passed++;
                tick();
            end
        end
    endtask

    task automatic test_restart_vs_timeout();
        apply_reset();
        while (e < P - 1) tick();
        i_restart = 1'b1;
        tick();
        i_restart = 1'b0;
        e = 0;
        while (e <= 20) begin
            got = observe(); exp = model(e, -1); total++;
            if (got !== exp) $display("FAIL restart_vs_timeout e=%0d got=%h exp=%h", e, got, exp); else passed++;
            tick();
        end
    endtask
`else
    task automatic test_no_timeout();
        apply_reset();
        while (e <= 510) begin
            drive(500, 0, 500, 0);
            got = observe(); exp = model(e, 503); total++;
            if (got !== exp) $display("FAIL no_timeout e=%0d got=%h exp=%h", e, got, exp); else passed++;
            tick();
        end
    endtask
`endif

    initial begin
        #500000;
        $display("FAIL watchdog e=%0d expired", e);
        $fatal(1, "watchdog");
    end

    initial begin
        total = 0;
        passed = 0;
        e = 0;
        iRST = 1'b1;
        i_restart = 1'b0;
        done_in = '0;
        @(negedge iCLK);
        test_reset();
        test_basic();
        test_sticky();
        test_random();
        test_restart_in_rst();
        test_restart_vs_completion();
        test_async_reset();
`ifdef DDR_INIT_TIMEOUT_EN
        test_timeout();
        test_restart_err();
        test_timeout_boundary();
        test_restart_vs_timeout();
`else
        test_no_timeout();
`endif
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
